// File: rtl/axi_pkg.sv
// Shared AXI4 types, response codes and burst address stepping.
// Both the read and write channels use next_addr so they agree on bursts.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [31:0] next_addr(
    input logic [31:0] addr,
    input logic [2:0]  size,
    input logic [7:0]  len,
    input logic [1:0]  burst
  );
    logic [31:0] step;
    logic [31:0] mask;
    logic [31:0] inc;
    logic        wrap_ok;
    step = 32'd1 << size;
    mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    inc  = addr + step;
    wrap_ok = (len == 8'd1) || (len == 8'd3) ||
              (len == 8'd7) || (len == 8'd15);
    if (burst == BURST_FIXED) return addr;
    // Odd WRAP lengths fall back to INCR stepping
    if (burst == BURST_WRAP && wrap_ok)
      return (addr & ~mask) | (inc & mask);
    return inc;
  endfunction

endpackage

// File: rtl/axi_ram_slave_if.sv
// AXI4 bus bundle between an interconnect master port and the RAM slave.
// Ignored sideband fields are carried so the port list stays complete.
interface axi_ram_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_ram_mem.sv
// Simple dual-port RAM: byte-enabled write port, registered read port.
// Read and write of the same word in one cycle return the old contents.
module axi_ram_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 14,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic [STRB_WIDTH-1:0] we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**AW];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (we_i[b])
        mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i)
      rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 RAM slave with independent write (AW/W/B) and read (AR/R) FSMs.
// Read path: registered RAM stage feeding a stallable output register.
module axi_ram_slave
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic           clk,
  input  logic           rst,
  axi_ram_slave_if.slave s_axi
);
  localparam int LSB = clog2(STRB_WIDTH);
  localparam int WAW = ADDR_WIDTH - LSB;

  function automatic logic [2:0] clamp_size(input logic [2:0] sz);
    return (int'(sz) > LSB) ? 3'(LSB) : sz;
  endfunction

  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]            aw_len_q, aw_len_d;
  logic [2:0]            aw_size_q, aw_size_d;
  logic [1:0]            aw_burst_q, aw_burst_d;
  logic [7:0]            w_beat_q, w_beat_d;
  logic                  w_err_q, w_err_d;
  logic                  awready, wready, bvalid, w_last;
  logic [STRB_WIDTH-1:0] mem_we;

  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]            ar_len_q, ar_len_d;
  logic [2:0]            ar_size_q, ar_size_d;
  logic [1:0]            ar_burst_q, ar_burst_d;
  logic [8:0]            r_iss_q, r_iss_d;
  logic                  p1_valid_q, p1_valid_d;
  logic                  p1_last_q, p1_last_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  arready, out_ld, mem_re;
  logic [WAW-1:0]        mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  unused_sig;

  assign w_last = (w_beat_q == aw_len_q);

  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_beat_d   = w_beat_q;
    w_err_d    = w_err_q;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    mem_we     = '0;
    unique case (w_state_q)
      W_IDLE: begin
        awready = !rst;
        if (s_axi.awvalid && awready) begin
          aw_id_d    = s_axi.awid;
          aw_addr_d  = s_axi.awaddr;
          aw_len_d   = s_axi.awlen;
          aw_size_d  = clamp_size(s_axi.awsize);
          aw_burst_d = s_axi.awburst;
          w_beat_d   = '0;
          w_err_d    = 1'b0;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        wready = !rst;
        if (s_axi.wvalid && wready) begin
          mem_we    = s_axi.wstrb;
          aw_addr_d = ADDR_WIDTH'(next_addr(32'(aw_addr_q),
                        aw_size_q, aw_len_q, aw_burst_q));
          w_beat_d  = w_beat_q + 8'd1;
          // Beat count ends the burst; wlast only grades the response
          if (s_axi.wlast != w_last) w_err_d = 1'b1;
          if (w_last) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = !rst;
        if (s_axi.bready && bvalid) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d  = r_state_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    r_iss_d    = r_iss_q;
    p1_valid_d = p1_valid_q;
    p1_last_d  = p1_last_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rdata_d    = rdata_q;
    arready    = 1'b0;
    mem_re     = 1'b0;
    mem_raddr  = ar_addr_q[ADDR_WIDTH-1:LSB];
    out_ld     = !rvalid_q || s_axi.rready;
    if (out_ld) begin
      rvalid_d   = p1_valid_q;
      p1_valid_d = 1'b0;
      if (p1_valid_q) begin
        rdata_d = mem_rdata;
        rlast_d = p1_last_q;
      end
    end
    unique case (r_state_q)
      R_IDLE: begin
        arready = !rst;
        if (s_axi.arvalid && arready) begin
          ar_id_d    = s_axi.arid;
          ar_len_d   = s_axi.arlen;
          ar_size_d  = clamp_size(s_axi.arsize);
          ar_burst_d = s_axi.arburst;
          ar_addr_d  = ADDR_WIDTH'(next_addr(32'(s_axi.araddr),
                         clamp_size(s_axi.arsize), s_axi.arlen,
                         s_axi.arburst));
          // First beat is fetched straight from the AR address
          mem_re     = 1'b1;
          mem_raddr  = s_axi.araddr[ADDR_WIDTH-1:LSB];
          p1_valid_d = 1'b1;
          p1_last_d  = (s_axi.arlen == 8'd0);
          r_iss_d    = 9'd1;
          r_state_d  = R_DATA;
        end
      end
      R_DATA: begin
        if ((!p1_valid_q || out_ld) &&
            (r_iss_q <= {1'b0, ar_len_q})) begin
          mem_re     = 1'b1;
          ar_addr_d  = ADDR_WIDTH'(next_addr(32'(ar_addr_q),
                         ar_size_q, ar_len_q, ar_burst_q));
          r_iss_d    = r_iss_q + 9'd1;
          p1_valid_d = 1'b1;
          p1_last_d  = (r_iss_q == {1'b0, ar_len_q});
        end
        if (rvalid_q && s_axi.rready && rlast_q)
          r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_beat_q   <= '0;
      w_err_q    <= 1'b0;
      r_state_q  <= R_IDLE;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_iss_q    <= '0;
      p1_valid_q <= 1'b0;
      p1_last_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_beat_q   <= w_beat_d;
      w_err_q    <= w_err_d;
      r_state_q  <= r_state_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_iss_q    <= r_iss_d;
      p1_valid_q <= p1_valid_d;
      p1_last_q  <= p1_last_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rdata_q    <= rdata_d;
    end
  end

  axi_ram_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .AW        (WAW),
    .STRB_WIDTH(STRB_WIDTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(aw_addr_q[ADDR_WIDTH-1:LSB]),
    .wdata_i(s_axi.wdata),
    .re_i   (mem_re),
    .raddr_i(mem_raddr),
    .rdata_o(mem_rdata)
  );

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bid     = aw_id_q;
  assign s_axi.bresp   = w_err_q ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.arready = arready;
  assign s_axi.rvalid  = rvalid_q && !rst;
  assign s_axi.rid     = ar_id_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = RESP_OKAY;
  assign s_axi.rlast   = rlast_q;

  assign unused_sig = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot,
                        s_axi.arlock, s_axi.arcache, s_axi.arprot};
endmodule

// File: tb/tb_axi_ram_slave.sv
// Randomized bench for axi_ram_slave against a byte-level memory model.
// Beat addresses are computed in closed form from the burst rules.
module tb_axi_ram_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  axi_ram_slave_if #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)
  ) s ();

  axi_ram_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .s_axi(s)
  );

  logic [31:0] mdata  [16384];
  logic [3:0]  mvalid [16384];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  logic [31:0] rd_q [$];
  logic        rl_q [$];
  logic [7:0]  rid_q [$];
  int          rc_q [$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] beat_addr(
    input logic [15:0] a, input logic [2:0] sz,
    input logic [7:0] len, input logic [1:0] bt, input int i);
    int es, step, win, base, off;
    es   = (sz > 3'd2) ? 2 : int'(sz);
    step = 1 << es;
    if (bt == 2'd0) return a;
    if (bt == 2'd2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      win  = (int'(len) + 1) * step;
      base = (int'(a) / win) * win;
      off  = int'(a) - base;
      return 16'(base + (off + i * step) % win);
    end
    return 16'(int'(a) + i * step);
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] v);
    return {{8{v[3]}}, {8{v[2]}}, {8{v[1]}}, {8{v[0]}}};
  endfunction

  task automatic model_wr(input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] st);
    logic [13:0] w;
    w = a[15:2];
    for (int b = 0; b < 4; b++) begin
      if (st[b]) begin
        mdata[w][8*b +: 8] = d[8*b +: 8];
        mvalid[w][b] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_wr(input logic [7:0] id, input logic [15:0] addr,
                        input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] burst, input int last_beat,
                        input int bstall, output logic [7:0] bid,
                        output logic [1:0] bresp);
    int cnt;
    s.awid = id; s.awaddr = addr; s.awlen = len;
    s.awsize = size; s.awburst = burst; s.awvalid = 1'b1;
    cnt = 0;
    while (!s.awready && cnt < 100) begin tick(); cnt++; end
    if (!s.awready) chk("aw_timeout", 0, 1);
    tick();
    s.awvalid = 1'b0;
    chk("w_turnaround", s.wready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      s.wdata = wbuf[i]; s.wstrb = sbuf[i];
      s.wlast = (i == last_beat); s.wvalid = 1'b1;
      cnt = 0;
      while (!s.wready && cnt < 100) begin tick(); cnt++; end
      if (!s.wready) chk("w_timeout", 0, 1);
      tick();
      model_wr(beat_addr(addr, size, len, burst, i), wbuf[i], sbuf[i]);
    end
    s.wvalid = 1'b0; s.wlast = 1'b0;
    chk("b_latency", s.bvalid, 1);
    for (int k = 0; k < bstall; k++) begin
      chk("b_hold", s.bvalid, 1);
      chk("b_stall_awready", s.awready, 0);
      tick();
    end
    cnt = 0;
    while (!s.bvalid && cnt < 100) begin tick(); cnt++; end
    if (!s.bvalid) chk("b_timeout", 0, 1);
    bid = s.bid; bresp = s.bresp;
    s.bready = 1'b1;
    tick();
    s.bready = 1'b0;
  endtask

  task automatic axi_rd(input logic [7:0] id, input logic [15:0] addr,
                        input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] burst, input int mode);
    int cnt, cyc, first, nb;
    logic rr, held_v, held_l;
    logic [31:0] held_d, m;
    logic [13:0] w;
    rd_q.delete(); rl_q.delete(); rid_q.delete(); rc_q.delete();
    s.arid = id; s.araddr = addr; s.arlen = len;
    s.arsize = size; s.arburst = burst; s.arvalid = 1'b1;
    cnt = 0;
    while (!s.arready && cnt < 100) begin tick(); cnt++; end
    if (!s.arready) chk("ar_timeout", 0, 1);
    tick();
    s.arvalid = 1'b0;
    cyc = 1; first = -1; nb = 0; held_v = 1'b0;
    held_d = '0; held_l = 1'b0;
    while (nb <= int'(len) && cyc < 3000) begin
      if (held_v) begin
        chk("r_hold_valid", s.rvalid, 1);
        chk("r_hold_data", s.rdata, held_d);
        chk("r_hold_last", s.rlast, held_l);
      end
      case (mode)
        0: rr = 1'b1;
        1: rr = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      s.rready = rr;
      held_v = 1'b0;
      if (s.rvalid) begin
        if (first < 0) first = cyc;
        if (rr) begin
          rd_q.push_back(s.rdata); rl_q.push_back(s.rlast);
          rid_q.push_back(s.rid); rc_q.push_back(cyc);
          nb++;
        end else begin
          held_v = 1'b1; held_d = s.rdata; held_l = s.rlast;
        end
      end
      tick();
      cyc++;
    end
    s.rready = 1'b0;
    if (nb <= int'(len)) chk("r_timeout", nb, int'(len) + 1);
    chk("r_first_latency", first, 2);
    chk("r_done_rvalid", s.rvalid, 0);
    chk("r_done_arready", s.arready, 1);
    for (int i = 0; i < rd_q.size(); i++) begin
      w = beat_addr(addr, size, len, burst, i) >> 2;
      m = lane_mask(mvalid[w]);
      chk("rdata", rd_q[i] & m, mdata[w] & m);
      chk("rlast", rl_q[i], i == int'(len));
      chk("rid", rid_q[i], id);
      if (mode == 0) chk("r_back2back", rc_q[i], rc_q[0] + i);
    end
  endtask

  task automatic chk_quiet();
    chk("rst_awready", s.awready, 0);
    chk("rst_wready", s.wready, 0);
    chk("rst_arready", s.arready, 0);
    chk("rst_bvalid", s.bvalid, 0);
    chk("rst_rvalid", s.rvalid, 0);
    chk("rst_bid", s.bid, 0);
    chk("rst_bresp", s.bresp, 0);
    chk("rst_rid", s.rid, 0);
    chk("rst_rdata", s.rdata, 0);
    chk("rst_rresp", s.rresp, 0);
    chk("rst_rlast", s.rlast, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic [7:0]  len;
    logic [15:0] a;
    logic [31:0] exp_q [$];
    for (int i = 0; i < 16384; i++) begin
      mdata[i] = '0; mvalid[i] = '0;
    end
    s.awid = '0; s.awaddr = '0; s.awlen = '0; s.awsize = '0;
    s.awburst = '0; s.awlock = '0; s.awcache = '0; s.awprot = '0;
    s.awvalid = 1'b0; s.wdata = '0; s.wstrb = '0; s.wlast = 1'b0;
    s.wvalid = 1'b0; s.bready = 1'b0;
    s.arid = '0; s.araddr = '0; s.arlen = '0; s.arsize = '0;
    s.arburst = '0; s.arlock = '0; s.arcache = '0; s.arprot = '0;
    s.arvalid = 1'b0; s.rready = 1'b0;

    repeat (3) tick();
    chk_quiet();
    rst = 1'b0;
    #1;
    chk("post_rst_awready", s.awready, 1);
    chk("post_rst_arready", s.arready, 1);
    tick();

    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    axi_wr(8'h5A, 16'h0010, 8'd0, 3'd2, 2'd1, 0, 0, bid, bresp);
    chk("single_bresp", bresp, 0);
    chk("single_bid", bid, 8'h5A);
    axi_rd(8'hA5, 16'h0010, 8'd0, 3'd2, 2'd1, 0);
    chk("single_rdata", rd_q[0], 32'hDEADBEEF);

    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF;
    end
    axi_wr(8'h11, 16'h0100, 8'd3, 3'd2, 2'd1, 3, 0, bid, bresp);
    chk("incr_bresp", bresp, 0);
    axi_rd(8'h12, 16'h0100, 8'd3, 3'd2, 2'd1, 0);
    for (int i = 0; i < 4; i++) chk("incr_rdata", rd_q[i], i + 1);

    axi_wr(8'h21, 16'h0108, 8'd3, 3'd2, 2'd2, 3, 0, bid, bresp);
    axi_rd(8'h22, 16'h0100, 8'd3, 3'd2, 2'd1, 0);
    exp_q = '{32'd3, 32'd4, 32'd1, 32'd2};
    for (int i = 0; i < 4; i++) chk("wrap_rdata", rd_q[i], exp_q[i]);

    wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
    axi_wr(8'h31, 16'h0200, 8'd0, 3'd2, 2'd1, 0, 0, bid, bresp);
    wbuf[0] = 32'h0; sbuf[0] = 4'h5;
    axi_wr(8'h32, 16'h0200, 8'd0, 3'd2, 2'd1, 0, 0, bid, bresp);
    axi_rd(8'h33, 16'h0200, 8'd0, 3'd2, 2'd1, 0);
    chk("strb_rdata", rd_q[0], 32'hFF00FF00);

    axi_rd(8'h41, 16'h0100, 8'd3, 3'd2, 2'd1, 1);
    for (int i = 0; i < 4; i++) chk("bp_rdata", rd_q[i], exp_q[i]);
    wbuf[0] = 32'h0BADF00D; sbuf[0] = 4'hF;
    axi_wr(8'h42, 16'h0204, 8'd0, 3'd2, 2'd1, 0, 5, bid, bresp);
    chk("bp_bid", bid, 8'h42);

    s.awid = 8'h51; s.awaddr = 16'h0400; s.awlen = 8'd3;
    s.awsize = 3'd2; s.awburst = 2'd1; s.awvalid = 1'b1;
    tick();
    s.awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s.wdata = 32'hA0 + 32'(i); s.wstrb = 4'hF; s.wlast = 1'b0;
      s.wvalid = 1'b1;
      tick();
      model_wr(16'h0400 + 16'(4 * i), 32'hA0 + 32'(i), 4'hF);
    end
    s.wdata = 32'hA2;
    rst = 1'b1;
    #1;
    chk("midrst_wready", s.wready, 0);
    tick();
    tick();
    chk_quiet();
    s.wvalid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_awready", s.awready, 1);
    for (int k = 0; k < 3; k++) begin
      chk("midrst_no_bvalid", s.bvalid, 0);
      tick();
    end
    axi_rd(8'h52, 16'h0400, 8'd3, 3'd2, 2'd1, 0);
    chk("midrst_beat0", rd_q[0], 32'hA0);
    chk("midrst_beat1", rd_q[1], 32'hA1);
    wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
    axi_wr(8'h53, 16'h0410, 8'd0, 3'd2, 2'd1, 0, 0, bid, bresp);
    chk("midrst_new_bresp", bresp, 0);
    chk("midrst_new_bid", bid, 8'h53);
    for (int i = 0; i < 3; i++) begin
      wbuf[i] = 32'hC0 + 32'(i); sbuf[i] = 4'hF;
    end
    axi_wr(8'h54, 16'h0420, 8'd2, 3'd2, 2'd1, 1, 0, bid, bresp);
    chk("early_wlast_bresp", bresp, 2);
    for (int i = 0; i < 3; i++) begin
      wbuf[i] = 32'hC8 + 32'(i); sbuf[i] = 4'hF;
    end
    axi_wr(8'h55, 16'h0420, 8'd2, 3'd2, 2'd1, 2, 0, bid, bresp);
    chk("after_err_bresp", bresp, 0);

    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'hE0 + 32'(i); sbuf[i] = 4'hF;
    end
    axi_wr(8'h61, 16'hFFF8, 8'd3, 3'd2, 2'd1, 3, 0, bid, bresp);
    axi_rd(8'h62, 16'hFFF8, 8'd3, 3'd2, 2'd1, 2);
    chk("addr_wrap_beat2", rd_q[2], 32'hE2);

    for (int i = 0; i < 256; i++) begin
      wbuf[i] = $urandom; sbuf[i] = 4'hF;
    end
    axi_wr(8'h71, 16'h1000, 8'd255, 3'd2, 2'd1, 255, 0, bid, bresp);
    chk("long_bresp", bresp, 0);
    axi_rd(8'h72, 16'h1000, 8'd255, 3'd2, 2'd1, 0);

    for (int i = 0; i < 8; i++) begin
      wbuf[i] = $urandom; sbuf[i] = 4'hF;
    end
    fork
      axi_wr(8'h81, 16'h0300, 8'd7, 3'd2, 2'd1, 7, 0, bid, bresp);
      axi_rd(8'h82, 16'h0100, 8'd3, 3'd2, 2'd1, 0);
    join
    chk("conc_bresp", bresp, 0);
    axi_rd(8'h83, 16'h0300, 8'd7, 3'd2, 2'd1, 2);

    for (int n = 0; n < 60; n++) begin
      a = 16'($urandom_range(0, 1023));
      case ($urandom_range(0, 3))
        0: len = 8'd0;
        1: len = 8'($urandom_range(0, 3));
        2: len = 8'((2 << $urandom_range(0, 3)) - 1);
        default: len = 8'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(len); i++) begin
          wbuf[i] = $urandom; sbuf[i] = 4'($urandom);
        end
        axi_wr(8'($urandom), a, len, 3'($urandom), 2'($urandom),
               int'(len), int'($urandom_range(0, 2)), bid, bresp);
        chk("rand_bresp", bresp, 0);
      end else begin
        axi_rd(8'($urandom), a, len, 3'($urandom), 2'($urandom), 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
